// File: rtl/y86_fetch_seq.sv
// rtl/y86_fetch_seq.sv - sequential Y86-64 fetch unit, one instruction byte per req/ack
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   fetch_start/start_pc one-cycle strobe and PC of the instruction to fetch
//   busy, done           fetch in progress / one-cycle completion pulse
//   mem_req/mem_addr     byte read request and address (stable while mem_req)
//   mem_ack/mem_data     read completion with data byte
//   mem_err              address error, qualified by mem_ack
//   icode, ifun, rA, rB  decoded instruction fields (rA/rB = 0xF when absent)
//   valC, valP           little-endian constant, address of next instruction
//   stat                 1=AOK 2=HLT 3=ADR 4=INS
module y86_fetch_seq #(
    parameter int MEM_TIMEOUT = 0,
    parameter int AW          = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_start,
    input  logic [AW-1:0] start_pc,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,
    input  logic          mem_err,
    output logic [3:0]    icode,
    output logic [3:0]    ifun,
    output logic [3:0]    rA,
    output logic [3:0]    rB,
    output logic [63:0]   valC,
    output logic [AW-1:0] valP,
    output logic [2:0]    stat
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic        TO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [31:0] TO_LAST = (MEM_TIMEOUT > 0) ? 32'(MEM_TIMEOUT - 1) : 32'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE0,
        S_REGS,
        S_CONST,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    state_t        byte0_next;
    logic [AW-1:0] pc_r;
    logic [3:0]    idx;       // bytes successfully read in this fetch
    logic [2:0]    cidx;      // constant byte position
    logic [31:0]   wait_cnt;  // consecutive requested cycles without ack
    logic          accept;
    logic          need_const;
    logic          timeout_hit;

    assign accept     = (state == S_IDLE) && fetch_start;
    assign mem_addr   = pc_r + {{(AW-4){1'b0}}, idx};
    assign need_const = (icode == 4'h3) || (icode == 4'h4) || (icode == 4'h5);
    // The Nth unanswered cycle ends the fetch; the counter holds N-1 at that point.
    assign timeout_hit = TO_EN && mem_req && !mem_ack && (wait_cnt == TO_LAST);

    // Where the first byte sends us, by its opcode nibble. Illegal opcodes,
    // halt and 1-byte instructions all finish immediately.
    always_comb begin
        byte0_next = S_DONE;
        case (mem_data[7:4])
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: byte0_next = S_REGS;
            4'h7, 4'h8:                               byte0_next = S_CONST;
            default:                                  byte0_next = S_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (fetch_start) state_next = S_BYTE0;
            end
            S_BYTE0: begin
                if (mem_ack)          state_next = mem_err ? S_DONE : byte0_next;
                else if (timeout_hit) state_next = S_DONE;
            end
            S_REGS: begin
                if (mem_ack)          state_next = (mem_err || !need_const) ? S_DONE : S_CONST;
                else if (timeout_hit) state_next = S_DONE;
            end
            S_CONST: begin
                if (mem_ack)          state_next = (mem_err || cidx == 3'd7) ? S_DONE : S_CONST;
                else if (timeout_hit) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // busy covers the DONE cycle where valP is formed; done is registered out of
    // that cycle, so it rises exactly as busy falls.
    always_comb begin
        busy    = 1'b0;
        mem_req = 1'b0;
        case (state)
            S_BYTE0, S_REGS, S_CONST: begin
                busy    = 1'b1;
                mem_req = 1'b1;
            end
            S_DONE:  busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r     <= '0;
            idx      <= 4'd0;
            cidx     <= 3'd0;
            wait_cnt <= 32'd0;
            icode    <= 4'h0;
            ifun     <= 4'h0;
            rA       <= 4'hF;
            rB       <= 4'hF;
            valC     <= 64'd0;
            valP     <= '0;
            stat     <= STAT_AOK;
            done     <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (accept) begin
                pc_r     <= start_pc;
                idx      <= 4'd0;
                cidx     <= 3'd0;
                wait_cnt <= 32'd0;
                rA       <= 4'hF;
                rB       <= 4'hF;
                valC     <= 64'd0;
                stat     <= STAT_AOK;
            end else if (mem_req) begin
                if (mem_ack) begin
                    wait_cnt <= 32'd0;
                    if (mem_err) begin
                        stat <= STAT_ADR;
                    end else begin
                        idx <= idx + 4'd1;
                        case (state)
                            S_BYTE0: begin
                                icode <= mem_data[7:4];
                                ifun  <= mem_data[3:0];
                                if (mem_data[7:4] > 4'hB)       stat <= STAT_INS;
                                else if (mem_data[7:4] == 4'h0) stat <= STAT_HLT;
                            end
                            S_REGS: begin
                                rA <= mem_data[7:4];
                                rB <= mem_data[3:0];
                            end
                            S_CONST: begin
                                valC[{cidx, 3'b000} +: 8] <= mem_data;
                                cidx                      <= cidx + 3'd1;
                            end
                            default: ;
                        endcase
                    end
                end else if (timeout_hit) begin
                    stat <= STAT_ADR;
                end else begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
            end else if (state == S_DONE) begin
                // idx counts only good bytes, so this is right for errors too
                valP <= pc_r + {{(AW-4){1'b0}}, idx};
            end
        end
    end

endmodule

// File: tb/tb_y86_fetch_seq.sv
// tb/tb_y86_fetch_seq.sv - directed bench for y86_fetch_seq
module tb_y86_fetch_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        fetch_start;
    logic [63:0] start_pc;
    logic        busy, done, mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        mem_err = 1'b0;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [2:0]  stat;

    logic        to_fetch_start;
    logic [63:0] to_start_pc;
    logic        to_busy, to_done, to_mem_req;
    logic [63:0] to_mem_addr;
    logic        to_mem_ack, to_mem_err;
    logic [7:0]  to_mem_data;
    logic [3:0]  to_icode, to_ifun, to_rA, to_rB;
    logic [63:0] to_valC, to_valP;
    logic [2:0]  to_stat;

    y86_fetch_seq dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .start_pc(start_pc),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .mem_err(mem_err),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP), .stat(stat)
    );

    y86_fetch_seq #(.MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .fetch_start(to_fetch_start), .start_pc(to_start_pc),
        .busy(to_busy), .done(to_done), .mem_req(to_mem_req), .mem_addr(to_mem_addr),
        .mem_ack(to_mem_ack), .mem_data(to_mem_data), .mem_err(to_mem_err),
        .icode(to_icode), .ifun(to_ifun), .rA(to_rA), .rB(to_rB), .valC(to_valC),
        .valP(to_valP), .stat(to_stat)
    );

    typedef struct {
        logic [63:0] pc;
        int          waits;
        bit          err_en;
        logic [63:0] err_addr;
        bit          poke;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        int          reads;
        int          lat;    // 0: latency not checked
    } vec_t;

    vec_t        vecs[10];
    logic [7:0]  mem [0:511];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wait_cfg = 0;
    bit          err_en = 1'b0;
    logic [63:0] err_addr = 64'd0;
    int          reads = 0;
    int          wcnt = 0;
    bit          prev_wait = 1'b0;
    logic [63:0] prev_addr = 64'd0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] pc, input int waits, input bit een,
                                input logic [63:0] eaddr, input bit poke,
                                input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc, input logic [63:0] vp,
                                input logic [2:0] st, input int rd, input int lat);
        vec_t v;
        v.pc = pc; v.waits = waits; v.err_en = een; v.err_addr = eaddr; v.poke = poke;
        v.icode = ic; v.ifun = fn; v.ra = ra; v.rb = rb; v.valc = vc; v.valp = vp;
        v.stat = st; v.reads = rd; v.lat = lat;
        return v;
    endfunction

    task automatic put_const(input int addr, input logic [63:0] val);
        for (int i = 0; i < 8; i++) mem[addr + i] = val[i*8 +: 8];
    endtask

    // Byte memory: answers after wait_cfg unanswered cycles, driven on the falling edge.
    always @(negedge clk) begin
        if (mem_req) begin
            if (prev_wait) check("addr_stable", mem_addr, prev_addr);
            if (wcnt >= wait_cfg) begin
                mem_ack   = 1'b1;
                mem_data  = mem[mem_addr[8:0]];
                mem_err   = err_en && (mem_addr == err_addr);
                reads     = reads + 1;
                wcnt      = 0;
                prev_wait = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_err   = 1'b0;
                wcnt      = wcnt + 1;
                prev_wait = 1'b1;
                prev_addr = mem_addr;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_err   = 1'b0;
            wcnt      = 0;
            prev_wait = 1'b0;
        end
    end

    task automatic run_fetch(input vec_t v, input string tag);
        int edges;
        bit seen;
        @(negedge clk);
        wait_cfg = v.waits; err_en = v.err_en; err_addr = v.err_addr; reads = 0;
        start_pc = v.pc; fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        check($sformatf("%s.busy_start", tag), 64'(busy), 64'(1));
        edges = 0;
        seen  = 1'b0;
        if (v.poke) begin
            @(negedge clk);
            start_pc = 64'h20; fetch_start = 1'b1;
            @(posedge clk); #1;
            fetch_start = 1'b0;
            edges = 1;
            if (done) seen = 1'b1;
        end
        while (!seen && edges < 300) begin
            @(posedge clk); #1;
            edges++;
            if (done) seen = 1'b1;
        end
        check($sformatf("%s.done_seen", tag), 64'(seen), 64'(1));
        if (v.lat != 0) check($sformatf("%s.latency", tag), 64'(edges), 64'(v.lat));
        check($sformatf("%s.busy_at_done", tag), 64'(busy), 64'(0));
        check($sformatf("%s.icode", tag), 64'(icode), 64'(v.icode));
        check($sformatf("%s.ifun", tag), 64'(ifun), 64'(v.ifun));
        check($sformatf("%s.rA", tag), 64'(rA), 64'(v.ra));
        check($sformatf("%s.rB", tag), 64'(rB), 64'(v.rb));
        check($sformatf("%s.valC", tag), valC, v.valc);
        check($sformatf("%s.valP", tag), valP, v.valp);
        check($sformatf("%s.stat", tag), 64'(stat), 64'(v.stat));
        check($sformatf("%s.reads", tag), 64'(reads), 64'(v.reads));
        @(posedge clk); #1;
        check($sformatf("%s.done_one_cycle", tag), 64'(done), 64'(0));
        if (v.poke) check($sformatf("%s.poke_ignored", tag), 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int dcount;
        bit seen;

        rst_n = 1'b0; fetch_start = 1'b0; start_pc = 64'd0;
        to_fetch_start = 1'b0; to_start_pc = 64'd0;
        to_mem_ack = 1'b0; to_mem_data = 8'h00; to_mem_err = 1'b0;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h000] = 8'h30; mem[9'h001] = 8'hF2; put_const(9'h002, 64'hA);
        mem[9'h100] = 8'h70; put_const(9'h101, 64'h20);
        mem[9'h020] = 8'h90; mem[9'h021] = 8'h00;
        mem[9'h040] = 8'hC0;
        mem[9'h050] = 8'h80; put_const(9'h051, 64'h8877665544332211);
        mem[9'h060] = 8'h61; mem[9'h061] = 8'h34;
        mem[9'h070] = 8'h50; mem[9'h071] = 8'h67; put_const(9'h072, 64'h0807060504030201);
        mem[9'h0A0] = 8'h40; mem[9'h0A1] = 8'h12; put_const(9'h0A2, 64'h1122334455667788);
        mem[9'h1FF] = 8'hA0;

        //        pc                 w  err addr      pk ic    fn    rA    rB    valC                   valP                   st    rd  lat
        vecs[0] = mk(64'h0,          0, 0, 64'h0,     0, 4'h3, 4'h0, 4'hF, 4'h2, 64'hA,                 64'hA,                 3'd1, 10, 11);
        vecs[1] = mk(64'h100,        0, 0, 64'h0,     0, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20,                64'h109,               3'd1, 9,  10);
        vecs[2] = mk(64'h20,         0, 0, 64'h0,     0, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h21,                3'd1, 1,  2);
        vecs[3] = mk(64'h21,         0, 0, 64'h0,     0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h22,                3'd2, 1,  2);
        vecs[4] = mk(64'h40,         0, 0, 64'h0,     1, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h41,                3'd4, 1,  2);
        vecs[5] = mk(64'h50,         3, 1, 64'h53,    0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h2211,              64'h53,                3'd3, 4,  0);
        vecs[6] = mk(64'h60,         1, 0, 64'h0,     0, 4'h6, 4'h1, 4'h3, 4'h4, 64'h0,                 64'h62,                3'd1, 2,  0);
        vecs[7] = mk(64'h70,         2, 0, 64'h0,     0, 4'h5, 4'h0, 4'h6, 4'h7, 64'h0807060504030201,  64'h7A,                3'd1, 10, 0);
        vecs[8] = mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h0, 0, 4'hA, 4'h0, 4'h3, 4'h0, 64'h0,          64'h1,                 3'd1, 2,  3);
        vecs[9] = mk(64'hA0,         1, 0, 64'h0,     0, 4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788,  64'hAA,                3'd1, 10, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.mem_req", 64'(mem_req), 64'(0));
        check("reset.mem_addr", mem_addr, 64'h0);
        check("reset.icode", 64'(icode), 64'(0));
        check("reset.ifun", 64'(ifun), 64'(0));
        check("reset.rA", 64'(rA), 64'hF);
        check("reset.rB", 64'(rB), 64'hF);
        check("reset.valC", valC, 64'h0);
        check("reset.valP", valP, 64'h0);
        check("reset.stat", 64'(stat), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_fetch(vecs[i], $sformatf("v%0d", i));

        // Timeout: no ack ever on the MEM_TIMEOUT=4 instance.
        @(negedge clk);
        to_start_pc = 64'h300; to_fetch_start = 1'b1;
        @(posedge clk); #1;
        to_fetch_start = 1'b0;
        check("to.mem_addr", to_mem_addr, 64'h300);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 50) begin
            @(posedge clk); #1;
            edges++;
            if (to_done) seen = 1'b1;
        end
        check("to.done_seen", 64'(seen), 64'(1));
        check("to.latency", 64'(edges), 64'(5));
        check("to.stat", 64'(to_stat), 64'(3));
        check("to.valP", to_valP, 64'h300);
        check("to.mem_req_after", 64'(to_mem_req), 64'(0));

        // Reset in the middle of the constant of rmmovq.
        @(negedge clk);
        wait_cfg = 1; err_en = 1'b0; reads = 0;
        start_pc = 64'hA0; fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        edges = 0;
        while (reads < 4 && edges < 100) begin
            @(posedge clk); #2;
            edges++;
        end
        check("rst.reached_const", 64'(reads >= 4), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst.mem_req", 64'(mem_req), 64'(0));
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        check("rst.rA", 64'(rA), 64'hF);
        check("rst.rB", 64'(rB), 64'hF);
        check("rst.valC", valC, 64'h0);
        check("rst.stat", 64'(stat), 64'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("rst.no_done", 64'(dcount), 64'(0));
        run_fetch(vecs[9], "v9_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
